lif_spike_sequencer: RTL
========================

// Module: lif_spike_sequencer
// PURPOSE
//  Digital controller that sequences the analog LIF neuron for one measurement window.
//  Drives the neuron's stimulus switch (stim_out) with a programmable pulse train.
//  Detects output spikes from the membrane comparator and forces a refractory membrane reset (mem_reset).
//  Counts spikes over the window; sits between the tt_um top-level pin mapping and the analog macro.
// PARAMETERS
//  SYNC_STAGES  2   flops in the spike_in synchronizer (>=2)
//  CNT_W        8   width of spike_count
//  WIN_W        16  width of window_len / window counter
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      1-cycle request to begin a window; ignored while busy=1
//  stim_period  in   8      stimulus period in cycles; 0 = stimulus disabled
//  stim_width   in   4      stimulus high time in cycles per period
//  refr_cycles  in   8      refractory length in cycles (0 treated as 1)
//  window_len   in   WIN_W  window length in cycles
//  spike_in     in   1      async comparator output from the neuron; a spike is a rising edge
//  stim_out     out  1      stimulus switch enable to the analog input
//  mem_reset    out  1      membrane discharge switch enable
//  spike_pulse  out  1      1-cycle strobe per counted spike
//  spike_count  out  CNT_W  spikes counted in the current/last window, saturating
//  busy         out  1      high in RUN and REFRACT
//  done         out  1      1-cycle strobe at window end
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; synchronizer flops 0; counters 0.
//  Config: stim_period, stim_width, refr_cycles and window_len are captured on an accepted start.
//  Config changes mid-window have no effect.
//  FSM states and transitions:
//   IDLE -> RUN on start. On the same edge: spike_count=0, window counter=0, phase counter=0.
//   RUN -> REFRACT on a detected spike edge.
//   RUN/REFRACT -> DONE when the window counter reaches window_len-1.
//   REFRACT -> RUN after the captured refr_cycles (min 1) have elapsed; phase counter restarts at 0.
//   DONE -> IDLE the next cycle; done=1 only in the DONE state.
//  Window: the window counter increments every cycle in RUN and REFRACT.
//   RUN+REFRACT last exactly window_len cycles in total.
//   Expiry truncates REFRACT: mem_reset drops when DONE is entered.
//   window_len=0 behaves as 1.
//  Stimulus: stim_out=1 iff state==RUN && stim_period!=0 && phase<stim_width.
//   phase counts 0..stim_period-1 and wraps.
//   If stim_width>=stim_period, stim_out stays high throughout RUN.
//   stim_width=0 gives no pulses. stim_out=0 in IDLE, REFRACT and DONE.
//  Spike detect: spike_in passes through SYNC_STAGES flops; edge = sync & ~sync_d.
//   The synchronizer runs in all states.
//   An edge in RUN: spike_pulse=1 that cycle, spike_count+1 (saturating at 2^CNT_W-1), next state REFRACT.
//   mem_reset=1 for every cycle in REFRACT.
//   Edges seen in IDLE, REFRACT or DONE are neither counted nor pulsed.
//   A spike edge in the final window cycle is counted, and the FSM goes to DONE (not REFRACT).
//  Latency: spike_pulse asserts SYNC_STAGES+1 edges after spike_in is first sampled high.
//   mem_reset asserts on the following cycle.
//  spike_count holds its value through IDLE until the next accepted start.
//  rst mid-window: return to IDLE, all outputs 0 on the next edge.
// TESTING
//  1 stim_period=10, stim_width=3, window_len=40, spike_in=0 -> 4 stim pulses of 3 cycles;
//    done at cycle 40; spike_count=0.
//  2 window_len=100, refr_cycles=5, spike_in rises at cycle 20 (SYNC_STAGES=2) -> spike_pulse at 23;
//    stim_out=0 and mem_reset=1 for cycles 24..28; count=1.
//  3 spike_in toggles every 2 cycles during REFRACT -> no extra counts;
//    the first edge after REFRACT is counted.
//  4 CNT_W=8, 300 well-spaced spikes in the window -> spike_count saturates at 255.
//  5 start while busy; a config change mid-window; stim_period=0; stim_width>=period
//    -> ignored, ignored, stim_out=0, and stim_out held high, respectively.
//  6 rst asserted mid-REFRACT -> next cycle state IDLE, mem_reset=0, busy=0, count=0;
//    window_len=0 -> done one cycle after RUN entry.

Source files
------------

// File: rtl/lif_spike_sequencer.sv
// Sequences one LIF measurement window: stimulus pulse train, spike detect,
// refractory reset, saturating spike count.
// Ports: clk, rst (sync, high); start + config in; spike_in (async) in;
// stim_out, mem_reset, spike_pulse, spike_count, busy, done out.
module lif_spike_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       stim_period,
  input  logic [3:0]       stim_width,
  input  logic [7:0]       refr_cycles,
  input  logic [WIN_W-1:0] window_len,
  input  logic             spike_in,
  output logic             stim_out,
  output logic             mem_reset,
  output logic             spike_pulse,
  output logic [CNT_W-1:0] spike_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REFRACT,
    DONE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   edge_q;

  logic [7:0]       cfg_period;
  logic [3:0]       cfg_width;
  logic [7:0]       cfg_refr_last;
  logic [WIN_W-1:0] cfg_win_last;

  logic [WIN_W-1:0] win_cnt;
  // Stimulus phase in RUN, refractory elapsed count in REFRACT.
  logic [7:0]       phase;
  logic [CNT_W-1:0] count_q;
  logic             win_end;

  assign win_end = (win_cnt == cfg_win_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], spike_in};
      sync_d <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~sync_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_period    <= '0;
      cfg_width     <= '0;
      cfg_refr_last <= '0;
      cfg_win_last  <= '0;
      win_cnt       <= '0;
      phase         <= '0;
      count_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            cfg_period <= stim_period;
            cfg_width  <= stim_width;
            cfg_refr_last <= (refr_cycles == 8'd0) ?
                             8'd0 : refr_cycles - 8'd1;
            cfg_win_last  <= (window_len == '0) ?
                             '0 : window_len - WIN_W'(1);
            win_cnt <= '0;
            phase   <= '0;
            count_q <= '0;
          end
        end
        RUN: begin
          win_cnt <= win_cnt + WIN_W'(1);
          if (cfg_period == 8'd0 || phase == cfg_period - 8'd1)
            phase <= '0;
          else
            phase <= phase + 8'd1;
          if (edge_q && count_q != '1)
            count_q <= count_q + CNT_W'(1);
          // Expiry wins over a last-cycle spike: counted, no refractory.
          if (win_end) begin
            state <= DONE;
          end else if (edge_q) begin
            state <= REFRACT;
            phase <= '0;
          end
        end
        REFRACT: begin
          win_cnt <= win_cnt + WIN_W'(1);
          phase   <= phase + 8'd1;
          if (win_end) begin
            state <= DONE;
          end else if (phase == cfg_refr_last) begin
            state <= RUN;
            phase <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stim_out    = (state == RUN) && (cfg_period != 8'd0) &&
                       (phase < {4'd0, cfg_width});
  assign mem_reset   = (state == REFRACT);
  assign spike_pulse = (state == RUN) && edge_q;
  assign spike_count = count_q;
  assign busy        = (state == RUN) || (state == REFRACT);
  assign done        = (state == DONE);

endmodule
